// File: rtl/adc_frame_sched_pkg.sv
// adc_frame_sched_pkg: shared widths, scheduler state encoding and read-port ownership helper
package adc_frame_sched_pkg;
  localparam int SMPL_ADDR_W = 6;
  localparam int SMPL_W = 16;
  localparam int SCHED_TIMER_W = 24;
  localparam int FRAME_CNT_W = 16;
  typedef enum logic [2:0] {
    SCHED_IDLE   = 3'd0,
    SCHED_ARM    = 3'd1,
    SCHED_FREEZE = 3'd2,
    SCHED_PROC   = 3'd3,
    SCHED_HOLD   = 3'd4
  } sched_state_e;
  function automatic logic fft_owns_port(sched_state_e s);
    return (s == SCHED_FREEZE) || (s == SCHED_PROC);
  endfunction
endpackage

// File: rtl/adc_frame_sched_if.sv
// adc_frame_sched_if: config, ADC buffer, FFT, host read and status signals of the frame scheduler
interface adc_frame_sched_if
  import adc_frame_sched_pkg::*;
#(
  parameter int ADDR_W = SMPL_ADDR_W,
  parameter int DATA_W = SMPL_W,
  parameter int TIMER_W = SCHED_TIMER_W
);
  logic cfg_go, cfg_stop, cfg_cont;
  logic [TIMER_W-1:0] cfg_interval;
  logic adc_enable, adc_valid;
  logic [ADDR_W-1:0] adc_addr;
  logic [DATA_W-1:0] adc_data;
  logic fft_start, fft_done;
  logic [ADDR_W-1:0] fft_addr;
  logic [DATA_W-1:0] fft_data;
  logic host_req, host_ack;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_rdata;
  logic busy, overrun, fft_timeout, irq;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  modport slave (
    input cfg_go, cfg_stop, cfg_cont, cfg_interval, adc_valid, adc_data,
          fft_done, fft_addr, host_req, host_addr,
    output adc_enable, adc_addr, fft_start, fft_data, host_ack, host_rdata,
           busy, frame_cnt, overrun, fft_timeout, irq
  );
  modport master (
    output cfg_go, cfg_stop, cfg_cont, cfg_interval, adc_valid, adc_data,
           fft_done, fft_addr, host_req, host_addr,
    input adc_enable, adc_addr, fft_start, fft_data, host_ack, host_rdata,
          busy, frame_cnt, overrun, fft_timeout, irq
  );
endinterface

// File: rtl/adc_frame_sched.sv
// adc_frame_sched: gates ADC capture, launches FFT per frozen frame, arbitrates the sample buffer read port
module adc_frame_sched
  import adc_frame_sched_pkg::*;
#(
  parameter int ADDR_W = SMPL_ADDR_W,
  parameter int DATA_W = SMPL_W,
  parameter int TIMER_W = SCHED_TIMER_W,
  parameter int WDOG = 4096
) (
  input logic clk,
  input logic rst,
  adc_frame_sched_if.slave bus
);
  localparam int WW = $clog2(WDOG + 1);
  localparam logic [WW-1:0] WMAX = WW'(WDOG - 1);
  sched_state_e state_q;
  logic stop_pend_q, adc_enable_q, fft_start_q, irq_q, overrun_q, fft_timeout_q, host_ack_q;
  logic [WW-1:0] wdog_q;
  logic [TIMER_W-1:0] tmr_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic [DATA_W-1:0] host_rdata_q;
  logic [ADDR_W-1:0] rd_addr;
  logic fft_owns, host_take;
  assign fft_owns = fft_owns_port(state_q);
  // one-cycle gap after each ack caps the host at one read every two cycles
  assign host_take = bus.host_req && !fft_owns && !host_ack_q;
  assign rd_addr = fft_owns ? bus.fft_addr : bus.host_addr;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCHED_IDLE;
      stop_pend_q <= 1'b0;
      adc_enable_q <= 1'b0;
      fft_start_q <= 1'b0;
      irq_q <= 1'b0;
      overrun_q <= 1'b0;
      fft_timeout_q <= 1'b0;
      host_ack_q <= 1'b0;
      wdog_q <= '0;
      tmr_q <= '0;
      frame_cnt_q <= '0;
      host_rdata_q <= '0;
    end else begin
      fft_start_q <= 1'b0;
      irq_q <= 1'b0;
      host_ack_q <= host_take;
      if (host_take) host_rdata_q <= bus.adc_data;
      if (bus.adc_valid && state_q != SCHED_ARM) overrun_q <= 1'b1;
      // stop is deferred to the frame boundary so the ADC write pointer stays aligned
      if (bus.cfg_stop && state_q inside {SCHED_ARM, SCHED_FREEZE, SCHED_PROC}) stop_pend_q <= 1'b1;
      case (state_q)
        SCHED_IDLE: if (bus.cfg_go) begin
          state_q <= SCHED_ARM;
          adc_enable_q <= 1'b1;
          stop_pend_q <= bus.cfg_stop;
        end
        SCHED_ARM: if (bus.adc_valid) begin
          state_q <= SCHED_FREEZE;
          adc_enable_q <= 1'b0;
        end
        SCHED_FREEZE: begin
          state_q <= SCHED_PROC;
          fft_start_q <= 1'b1;
          wdog_q <= '0;
        end
        SCHED_PROC: begin
          wdog_q <= (wdog_q == WMAX) ? wdog_q : wdog_q + 1'b1;
          if (bus.fft_done) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
            irq_q <= 1'b1;
            if (stop_pend_q || bus.cfg_stop || !bus.cfg_cont) begin
              state_q <= SCHED_IDLE;
              stop_pend_q <= 1'b0;
            end else if (bus.cfg_interval == '0) begin
              state_q <= SCHED_ARM;
              adc_enable_q <= 1'b1;
            end else begin
              state_q <= SCHED_HOLD;
              tmr_q <= bus.cfg_interval;
            end
          end else if (wdog_q == WMAX) begin
            state_q <= SCHED_IDLE;
            fft_timeout_q <= 1'b1;
            stop_pend_q <= 1'b0;
          end
        end
        SCHED_HOLD: if (bus.cfg_stop) state_q <= SCHED_IDLE;
          else if (tmr_q == TIMER_W'(1)) begin
            state_q <= SCHED_ARM;
            adc_enable_q <= 1'b1;
          end else tmr_q <= tmr_q - 1'b1;
        default: state_q <= SCHED_IDLE;
      endcase
    end
  end
  assign bus.adc_enable = adc_enable_q;
  assign bus.adc_addr = rd_addr;
  assign bus.fft_start = fft_start_q;
  assign bus.fft_data = bus.adc_data;
  assign bus.host_ack = host_ack_q;
  assign bus.host_rdata = host_rdata_q;
  assign bus.busy = state_q != SCHED_IDLE;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.overrun = overrun_q;
  assign bus.fft_timeout = fft_timeout_q;
  assign bus.irq = irq_q;
endmodule

// File: tb/tb_adc_frame_sched.sv
// tb_adc_frame_sched: directed scenarios plus random traffic against an event-timestamp model of the scheduler
module tb_adc_frame_sched;
  import adc_frame_sched_pkg::*;
  localparam int WD = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [SMPL_W-1:0] mem [64];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit m_arm, m_fly, m_pend, m_ovr, m_tmo, m_ack;
  int m_start = -1, m_rearm = -1, m_irq = -1, m_cnt = 0;
  logic [SMPL_W-1:0] m_rdata = '0;
  adc_frame_sched_if bus ();
  adc_frame_sched #(.WDOG(WD)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.adc_data = mem[bus.adc_addr];
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  // model: capture window, in-flight frame and re-arm time tracked as timestamps
  always @(negedge clk) begin
    bit hold, busy, take;
    logic [SMPL_ADDR_W-1:0] ea;
    hold = cyc < m_rearm;
    busy = m_arm || m_fly || hold;
    ea = m_fly ? bus.fft_addr : bus.host_addr;
    chk("adc_enable", int'(bus.adc_enable), int'(m_arm));
    chk("fft_start", int'(bus.fft_start), int'(cyc == m_start));
    chk("busy", int'(bus.busy), int'(busy));
    chk("irq", int'(bus.irq), int'(cyc == m_irq));
    chk("frame_cnt", int'(bus.frame_cnt), m_cnt);
    chk("overrun", int'(bus.overrun), int'(m_ovr));
    chk("fft_timeout", int'(bus.fft_timeout), int'(m_tmo));
    chk("host_ack", int'(bus.host_ack), int'(m_ack));
    chk("host_rdata", int'(bus.host_rdata), int'(m_rdata));
    chk("adc_addr", int'(bus.adc_addr), int'(ea));
    chk("fft_data", int'(bus.fft_data), int'(mem[ea]));
    take = bus.host_req && !m_fly && !m_ack;
    if (rst) begin
      {m_arm, m_fly, m_pend, m_ovr, m_tmo, m_ack} = '0;
      m_rdata = '0;
      m_start = -1;
      m_rearm = -1;
      m_irq = -1;
      m_cnt = 0;
    end else begin
      if (bus.adc_valid && !m_arm) m_ovr = 1'b1;
      if (take) m_rdata = mem[bus.host_addr];
      m_ack = take;
      if (!busy) begin
        if (bus.cfg_go) begin
          m_arm = 1'b1;
          m_pend = bus.cfg_stop;
        end
      end else if (hold) begin
        if (bus.cfg_stop) m_rearm = -1;
        else if (cyc + 1 == m_rearm) m_arm = 1'b1;
      end else begin
        if (bus.cfg_stop) m_pend = 1'b1;
        if (m_arm && bus.adc_valid) begin
          m_arm = 1'b0;
          m_fly = 1'b1;
          m_start = cyc + 2;
        end else if (m_fly && cyc >= m_start) begin
          if (bus.fft_done) begin
            m_fly = 1'b0;
            m_cnt = (m_cnt + 1) % 65536;
            m_irq = cyc + 1;
            if (m_pend || !bus.cfg_cont) m_pend = 1'b0;
            else if (bus.cfg_interval == 0) m_arm = 1'b1;
            else m_rearm = cyc + 1 + int'(bus.cfg_interval);
          end else if (cyc - m_start == WD - 1) begin
            m_fly = 1'b0;
            m_tmo = 1'b1;
            m_pend = 1'b0;
          end
        end
      end
    end
    cyc++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic pulse_go();
    bus.cfg_go = 1'b1;
    tick();
    bus.cfg_go = 1'b0;
  endtask
  task automatic wait_en();
    int n;
    n = 0;
    while (!bus.adc_enable && n < 64) begin
      tick();
      n++;
    end
    if (!bus.adc_enable) chk("wait_adc_enable", 0, 1);
  endtask
  task automatic wait_start();
    int n;
    n = 1;
    while (!bus.fft_start && n < 64) begin
      tick();
      n++;
    end
    chk("start_latency", n, 2);
  endtask
  task automatic frame(input int dly);
    wait_en();
    bus.adc_valid = 1'b1;
    tick();
    bus.adc_valid = 1'b0;
    wait_start();
    repeat (dly) tick();
    bus.fft_done = 1'b1;
    tick();
    bus.fft_done = 1'b0;
  endtask
  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = SMPL_W'($urandom);
    {bus.cfg_go, bus.cfg_stop, bus.cfg_cont, bus.adc_valid, bus.fft_done, bus.host_req} = '0;
    bus.cfg_interval = '0;
    bus.fft_addr = '0;
    bus.host_addr = '0;
    do_reset();
    chk("rst_enable", int'(bus.adc_enable), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_cnt", int'(bus.frame_cnt), 0);
    chk("rst_flags", int'({bus.overrun, bus.fft_timeout, bus.irq, bus.host_ack}), 0);
    bus.cfg_cont = 1'b0;
    pulse_go();
    chk("t1_enable", int'(bus.adc_enable), 1);
    frame(3);
    chk("t1_irq", int'(bus.irq), 1);
    chk("t1_cnt", int'(bus.frame_cnt), 1);
    chk("t1_idle", int'({bus.busy, bus.adc_enable}), 0);
    do_reset();
    bus.cfg_cont = 1'b1;
    bus.cfg_interval = 24'd10;
    pulse_go();
    for (int f = 0; f < 3; f++) begin
      if (f == 2) bus.cfg_cont = 1'b0;
      frame(4);
      chk("t2_irq", int'(bus.irq), 1);
      if (f < 2) begin
        n = 0;
        while (!bus.adc_enable && n < 50) begin
          tick();
          n++;
        end
        chk("t2_hold_cycles", n, 10);
      end
    end
    chk("t2_cnt", int'(bus.frame_cnt), 3);
    chk("t2_idle", int'(bus.busy), 0);
    do_reset();
    bus.cfg_cont = 1'b1;
    bus.cfg_interval = 24'd5;
    pulse_go();
    tick();
    bus.cfg_stop = 1'b1;
    tick();
    bus.cfg_stop = 1'b0;
    frame(2);
    chk("t3_cnt_arm_stop", int'(bus.frame_cnt), 1);
    chk("t3_idle_arm_stop", int'(bus.busy), 0);
    pulse_go();
    frame(2);
    chk("t3_in_hold", int'({bus.busy, bus.adc_enable}), 2);
    tick();
    bus.cfg_stop = 1'b1;
    tick();
    bus.cfg_stop = 1'b0;
    chk("t3_idle_hold_stop", int'({bus.busy, bus.adc_enable}), 0);
    chk("t3_cnt_hold_stop", int'(bus.frame_cnt), 2);
    do_reset();
    bus.cfg_cont = 1'b1;
    pulse_go();
    wait_en();
    bus.adc_valid = 1'b1;
    tick();
    bus.adc_valid = 1'b0;
    wait_start();
    n = 0;
    while (!bus.fft_timeout && n < 40) begin
      tick();
      n++;
    end
    chk("t4_timeout_cycles", n, 16);
    chk("t4_idle", int'(bus.busy), 0);
    chk("t4_no_irq", int'(bus.irq), 0);
    chk("t4_cnt", int'(bus.frame_cnt), 0);
    bus.cfg_cont = 1'b0;
    pulse_go();
    frame(3);
    chk("t4_rego_cnt", int'(bus.frame_cnt), 1);
    chk("t4_sticky", int'(bus.fft_timeout), 1);
    do_reset();
    pulse_go();
    wait_en();
    bus.adc_valid = 1'b1;
    tick();
    bus.adc_valid = 1'b0;
    wait_start();
    bus.fft_addr = 6'd9;
    bus.host_addr = 6'd5;
    bus.host_req = 1'b1;
    #1;
    chk("t5_addr_fft", int'(bus.adc_addr), 9);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_stall", int'(bus.host_ack), 0);
    end
    bus.fft_done = 1'b1;
    tick();
    bus.fft_done = 1'b0;
    chk("t5_addr_host", int'(bus.adc_addr), 5);
    chk("t5_no_ack_yet", int'(bus.host_ack), 0);
    tick();
    bus.host_req = 1'b0;
    chk("t5_ack", int'(bus.host_ack), 1);
    chk("t5_rdata", int'(bus.host_rdata), int'(mem[5]));
    do_reset();
    bus.cfg_cont = 1'b1;
    bus.cfg_interval = 24'd20;
    pulse_go();
    frame(2);
    bus.adc_valid = 1'b1;
    tick();
    bus.adc_valid = 1'b0;
    chk("t6_overrun", int'(bus.overrun), 1);
    tick();
    tick();
    chk("t6_overrun_sticky", int'(bus.overrun), 1);
    wait_en();
    bus.adc_valid = 1'b1;
    tick();
    bus.adc_valid = 1'b0;
    wait_start();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_outputs", int'({bus.busy, bus.adc_enable, bus.fft_start, bus.irq, bus.overrun, bus.fft_timeout}), 0);
    chk("t6_rst_cnt", int'(bus.frame_cnt), 0);
    for (int k = 0; k < 3000; k++) begin
      bus.cfg_go = ($urandom_range(7) == 0);
      bus.cfg_stop = ($urandom_range(39) == 0);
      bus.cfg_cont = ($urandom_range(4) != 0);
      bus.cfg_interval = 24'($urandom_range(4));
      bus.adc_valid = bus.adc_enable ? ($urandom_range(3) == 0) : ($urandom_range(199) == 0);
      bus.fft_done = (bus.busy && !bus.adc_enable) ? ($urandom_range(5) == 0) : 1'b0;
      bus.fft_addr = 6'($urandom);
      if (bus.host_req && bus.host_ack) bus.host_req = ($urandom_range(3) == 0);
      else if (!bus.host_req && $urandom_range(2) == 0) begin
        bus.host_req = 1'b1;
        bus.host_addr = 6'($urandom);
      end
      rst = ($urandom_range(499) == 0);
      tick();
    end
    {bus.cfg_go, bus.cfg_stop, bus.adc_valid, bus.fft_done, bus.host_req} = '0;
    rst = 1'b0;
    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
